// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// alu_mc_if
// Handshake and data bundle between the operand stage, alu_mc and writeback.
//
// Handshake rules:
//   - Input side: a transfer happens on a rising clock edge where in_valid
//     and in_ready are both 1. A, B and ALUop are sampled only on that edge.
//   - Output side: a transfer happens on a rising clock edge where out_valid
//     and out_ready are both 1. Result and flags stay stable while out_valid
//     is 1 and out_ready is 0.
//
// Signals:
//   in_valid, A, B, ALUop      operand-stage -> ALU
//   in_ready                   ALU -> operand-stage
//   out_valid, Result, flags   ALU -> writeback
//   out_ready                  writeback -> ALU
// Modports: master (operand/writeback side), slave (ALU side).
// ---------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU. Logic, add/sub, compares and shifts finish in one cycle;
// MUL/MULHU (shift-add) and DIVU/REMU (restoring division) iterate one bit
// per cycle for DATA_WIDTH cycles. All results and flags are registered.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   io_bus       alu_mc_if.slave: in_valid/in_ready/A/B/ALUop,
//                out_valid/out_ready/Result/Overflow/CarryOut/Zero
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// DATA_WIDTH must be >= 4 and a power of two.
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_mc_if.slave     io_bus,
  output logic [1:0]  o_dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_cnt;
  logic [1:0]      r_op;     // low opcode bits: [1]=divide, [0]=high half
  logic [W-1:0]    r_hi;     // product high word / partial remainder
  logic [W-1:0]    r_lo;     // multiplier then product low / dividend then quotient
  logic [W-1:0]    r_opnd;   // multiplicand or divisor
  logic [W-1:0]    r_result;
  logic            r_ovf;
  logic            r_cout;
  logic            r_zero;

  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [3:0]      w_op;
  logic            w_accept;
  logic            w_iter_op;
  logic [SW-1:0]   w_shamt;
  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic            w_borrow;
  logic            w_slt;
  logic [W-1:0]    w_sc_result;
  logic            w_sc_cout;
  logic            w_sc_ovf;

  logic [W:0]      w_mul_sum;
  logic [W:0]      w_div_shift;
  logic [W:0]      w_div_sub;
  logic            w_div_ok;
  logic [W-1:0]    w_iter_hi;
  logic [W-1:0]    w_iter_lo;
  logic [W-1:0]    w_iter_res;

  assign w_a       = io_bus.A;
  assign w_b       = io_bus.B;
  assign w_op      = io_bus.ALUop;
  assign w_accept  = io_bus.in_valid && (r_state == S_IDLE);
  // MUL/MULHU/DIVU/REMU are exactly the opcodes 11xx.
  assign w_iter_op = (w_op[3:2] == 2'b11);
  assign w_shamt   = w_b[SW-1:0];

  // ---------------- single-cycle datapath ----------------
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
  assign w_borrow = w_diff[W];
  // Signed less-than: with differing signs the negative operand is smaller,
  // otherwise the unsigned borrow is the answer. Immune to subtract overflow.
  assign w_slt    = (w_a[W-1] != w_b[W-1]) ? w_a[W-1] : w_borrow;

  always_comb begin
    w_sc_result = '0;
    w_sc_cout   = 1'b0;
    w_sc_ovf    = 1'b0;
    case (w_op)
      4'b0000: w_sc_result = w_a & w_b;
      4'b0001: w_sc_result = w_a | w_b;
      4'b0010: begin
        w_sc_result = w_sum[W-1:0];
        w_sc_cout   = w_sum[W];
        w_sc_ovf    = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
      end
      4'b0110: begin
        w_sc_result = w_diff[W-1:0];
        w_sc_cout   = w_borrow;
        w_sc_ovf    = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
      end
      4'b0111: begin
        w_sc_result = {{(W-1){1'b0}}, w_slt};
        w_sc_cout   = w_borrow;
      end
      4'b0100: w_sc_result = w_a ^ w_b;
      4'b0101: w_sc_result = ~(w_a | w_b);
      4'b0011: begin
        w_sc_result = {{(W-1){1'b0}}, w_borrow};
        w_sc_cout   = w_borrow;
      end
      4'b1000: w_sc_result = w_a << w_shamt;
      4'b1001: w_sc_result = w_a >> w_shamt;
      4'b1010: w_sc_result = $signed(w_a) >>> w_shamt;
      default: w_sc_result = '0;  // reserved 1011; 11xx never uses this path
    endcase
  end

  // ---------------- iterative datapath ----------------
  // Shift-add: add the multiplicand into the high word when the current
  // multiplier bit is set, then shift the whole product right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  // Restoring division: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits. A zero divisor always "fits", which
  // yields an all-ones quotient and leaves the dividend as the remainder.
  assign w_div_shift = {r_hi, r_lo[W-1]};
  assign w_div_sub   = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});

  always_comb begin
    w_iter_hi = '0;
    w_iter_lo = '0;
    if (r_op[1]) begin
      w_iter_hi = w_div_ok ? w_div_sub[W-1:0] : w_div_shift[W-1:0];
      w_iter_lo = {r_lo[W-2:0], w_div_ok};
    end else begin
      w_iter_hi = w_mul_sum[W:1];
      w_iter_lo = {w_mul_sum[0], r_lo[W-1:1]};
    end
  end

  // MULHU and REMU take the high word, MUL and DIVU the low word.
  assign w_iter_res = r_op[0] ? w_iter_hi : w_iter_lo;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (io_bus.in_valid) w_next = w_iter_op ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == '0)     w_next = S_DONE;
      S_DONE: if (io_bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_op <= w_op[1:0];
      if (w_iter_op) begin
        r_cnt  <= CNT_LAST;
        r_hi   <= '0;
        r_lo   <= w_op[1] ? w_a : w_b;
        r_opnd <= w_op[1] ? w_b : w_a;
      end else begin
        r_result <= w_sc_result;
        r_ovf    <= w_sc_ovf;
        r_cout   <= w_sc_cout;
        r_zero   <= (w_sc_result == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_hi <= w_iter_hi;
      r_lo <= w_iter_lo;
      if (r_cnt == '0) begin
        r_result <= w_iter_res;
        r_ovf    <= 1'b0;
        r_cout   <= 1'b0;
        r_zero   <= (w_iter_res == '0);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.Result    = r_result;
  assign io_bus.Overflow  = r_ovf;
  assign io_bus.CarryOut  = r_cout;
  assign io_bus.Zero      = r_zero;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_RSV  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_MULH = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.DATA_WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flag_q[$];   // {Overflow, CarryOut, Zero}
  string        name_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {Overflow, CarryOut, Zero, Result}, computed with plain arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0]  r;
    logic          c;
    logic          v;
    longint        sa;
    longint        sb;
    longint        s;
    logic [63:0]   ua;
    logic [63:0]   ub;
    logic [63:0]   p;
    int            sh;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD: begin
        p = ua + ub;
        r = p[31:0];
        c = (p > 64'hFFFF_FFFF);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT:  begin r = (sa < sb) ? 1 : 0; c = (a < b); end
      OP_SLTU: begin r = (a < b) ? 1 : 0;   c = (a < b); end
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_MUL:  begin p = ua * ub; r = p[31:0];  end
      OP_MULH: begin p = ua * ub; r = p[63:32]; end
      OP_DIVU: r = (b == 0) ? '1 : a / b;
      OP_REMU: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return {v, c, (r == 0), r};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got Result 0x%0h with empty expected queue", bus.Result);
      end else begin
        logic [W-1:0] e;
        logic [2:0]   f;
        string        nm;
        e  = exp_q.pop_front();
        f  = exp_flag_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_result"}, bus.Result, e);
        chk({nm, "_flags"}, {bus.Overflow, bus.CarryOut, bus.Zero}, f);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string name);
    int n;
    logic [W+2:0] m;
    bus.ALUop    = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk({name, "_in_handshake_timeout"}, 0, 1);
    m = model(op, a, b);
    exp_q.push_back(m[W-1:0]);
    exp_flag_q.push_back(m[W+2:W]);
    name_q.push_back(name);
    @(posedge clk); #1;
    // Scramble operands: the ALU must ignore them from now on.
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.ALUop    = 4'($urandom_range(0, 15));
  endtask

  // Issue one op with out_ready low, measure latency and in_ready, optionally
  // hold the result under back-pressure, then accept it.
  task automatic directed(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, input int exp_lat, input int hold);
    int n;
    int rdy_seen;
    logic [W-1:0] res0;
    logic [2:0]   flg0;
    bus.out_ready = 1'b0;
    send(op, a, b, name);
    n = 1;
    rdy_seen = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) rdy_seen++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_in_ready_low_while_busy"}, rdy_seen, 0);
    res0 = bus.Result;
    flg0 = {bus.Overflow, bus.CarryOut, bus.Zero};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, bus.out_valid, 1);
      chk({name, "_hold_in_ready"}, bus.in_ready, 0);
      chk({name, "_hold_result"}, bus.Result, res0);
      chk({name, "_hold_flags"}, {bus.Overflow, bus.CarryOut, bus.Zero}, flg0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after_out"}, bus.in_ready, 1);
    chk({name, "_valid_drop_after_out"}, bus.out_valid, 0);
  endtask

  // Randomly toggle out_ready every cycle (also while busy) until accepted.
  task automatic wait_done_random(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid && bus.out_ready) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    if (!done) chk({name, "_out_timeout"}, 0, 1);
    else       chk({name, "_in_ready_after_out"}, bus.in_ready, 1);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUop     = '0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_result", bus.Result, 0);
    chk("reset_flags", {bus.Overflow, bus.CarryOut, bus.Zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", bus.in_ready, 1);

    directed(OP_ADD,  32'h7FFF_FFFF, 32'd1,         "add_ovf",   1,     0);
    directed(OP_SUB,  32'd1,         32'd2,         "sub_borrow", 1,    0);
    directed(OP_SLT,  32'h8000_0000, 32'd1,         "slt_neg",   1,     0);
    directed(OP_SLTU, 32'h8000_0000, 32'd1,         "sltu",      1,     0);
    directed(OP_SRA,  32'h8000_0000, 32'h3F,        "sra_31",    1,     0);
    directed(OP_SLL,  32'd1,         32'd32,        "sll_0",     1,     0);
    directed(OP_RSV,  32'h1234_5678, 32'h9,         "reserved",  1,     0);
    directed(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", W + 1, 0);
    directed(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max",   W + 1, 0);
    directed(OP_DIVU, 32'd100,       32'd0,         "divu_zero", W + 1, 0);
    directed(OP_REMU, 32'd100,       32'd7,         "remu_hold", W + 1, 10);

    // Reset in the middle of a division.
    send(OP_DIVU, 32'd1000, 32'd3, "divu_abort");
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_result", bus.Result, 0);
    chk("abort_flags", {bus.Overflow, bus.CarryOut, bus.Zero}, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    exp_q.delete();
    exp_flag_q.delete();
    name_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed(OP_ADD, 32'd2, 32'd3, "add_after_abort", 1, 0);

    // Randomized ops with random back-pressure.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      send(op, rand_opnd(), rand_opnd(), $sformatf("rand%0d_op%0h", i, op));
      wait_done_random($sformatf("rand%0d", i));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width ALU with a valid/ready handshake on both sides. It is the successor to the single-cycle combinational ALU. It extends the operation set with logic, unsigned-compare and shift ops, plus iterative unsigned multiply/divide, and registers all results. It sits between the decode/operand stage and writeback in the multi-cycle CPU and stalls the pipeline via `in_ready` while an iterative op runs.

## Interface
- `DATA_WIDTH`, 32: operand/result width; must be ≥ 4 and a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `A`, `B`  in  DATA_WIDTH  operands, sampled on input handshake.
- `ALUop`  in  4  operation code (see Operation).
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer accepts result.
- `Result`  out  DATA_WIDTH  registered result.
- `Overflow`, `CarryOut`, `Zero`  out  1 each  registered flags.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0100 XOR, 0101 NOR, 0011 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low word), 1101 MULHU (high word, unsigned), 1110 DIVU, 1111 REMU, 1011 reserved.
- The legacy 3-bit codes keep their meaning when zero-extended to 4 bits.
- Reserved opcode: Result 0, all flags 0 except Zero=1; it takes the single-cycle path.
- Shifts: the amount is `B[log2(DATA_WIDTH)-1:0]`; upper bits of B are ignored. SRA replicates `A[MSB]`.
- Flags:
  - Zero = (Result == 0) for every op.
  - CarryOut: ADD gives the carry out of bit MSB. SUB/SLT/SLTU give the borrow (1 iff A < B unsigned). All other ops give 0.
  - Overflow: ADD is set iff A and B share a sign and the sum sign differs. SUB is set iff the signs differ and the result sign ≠ A's sign. All other ops give 0.
  - SLT is correct across overflow: Result = (A < B) signed.
- MUL/MULHU: shift-add, one multiplier bit per cycle, with a 2·DATA_WIDTH-bit product register.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- Divide by zero: DIVU returns all-ones and REMU returns A. The op still takes full latency and no flag indicates the error.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, on `in_valid`: single-cycle op goes to DONE with result captured. Iterative op goes to BUSY, loads operands, and sets the counter to DATA_WIDTH−1.
  - BUSY: one iteration per cycle. When the counter is 0, the final iteration writes Result and flags and the state goes to DONE; otherwise the counter decrements.
  - DONE, on `out_ready`: go to IDLE.
- Operand inputs are ignored outside the IDLE handshake cycle. Changing A/B/ALUop during BUSY has no effect.

## Timing
- Reset (async assert, sync deassert is the system's job): state IDLE, counter 0, `out_valid` 0, `Result` 0, `Overflow` 0, `CarryOut` 0, `Zero` 0. `in_ready` is 1 immediately after reset.
- `in_ready` = (state == IDLE), combinational from state only, with no dependence on `out_ready`.
- Single-cycle ops: handshake in cycle T gives `out_valid` = 1 in cycle T+1.
- Iterative ops: handshake in cycle T gives `out_valid` = 1 in cycle T+DATA_WIDTH+1 (e.g. 33 for width 32).
- `out_valid` and all outputs are held stable in DONE until `out_ready`. Back-pressure of any length is legal.
- After the output handshake in cycle T, `in_ready` = 1 in T+1. There is no back-to-back accept in DONE, giving a maximum throughput of one op per 2 cycles.
- `out_ready` while not in DONE is ignored.
- Result/flags registers keep their last value after leaving DONE and update only when the next op completes.
- Reset asserted mid-BUSY or mid-DONE aborts the op immediately. The result is discarded and all outputs take their reset values.

## Test plan
- Reset, then ADD A=0x7FFFFFFF, B=1 -> next cycle `out_valid`=1, Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=1, B=2 -> Result=0xFFFFFFFF, CarryOut=1, Overflow=0. SLT A=0x80000000, B=1 -> Result=1. SLTU with the same operands -> Result=0.
- SRA A=0x80000000, B=0x3F -> Result=0xFFFFFFFF (amount 31). SLL A=1, B=32 -> Result=1 (amount 0).
- MULHU A=B=0xFFFFFFFF -> `in_ready`=0 for 32 cycles, `out_valid` at T+33, Result=0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- DIVU A=100, B=0 -> Result=0xFFFFFFFF. REMU A=100, B=7 -> Result=2. Hold `out_ready`=0 for 10 cycles and check that outputs stay stable and `in_ready`=0.
- Start DIVU, pull `rst_n` low at iteration 10 -> outputs go to 0 immediately, then `in_ready`=1. A new ADD 2+3 returns 5.
